// File: rtl/seq_stage_ctrl_pkg.sv
// Shared Y86-64 constants for the SEQ stage sequencer: icodes, status codes,
// stage state encoding and stage enable bit positions.
package y86_pkg;

  localparam logic [3:0] IHALT   = 4'h0;
  localparam logic [3:0] INOP    = 4'h1;
  localparam logic [3:0] IRRMOVQ = 4'h2;
  localparam logic [3:0] IIRMOVQ = 4'h3;
  localparam logic [3:0] IRMMOVQ = 4'h4;
  localparam logic [3:0] IMRMOVQ = 4'h5;
  localparam logic [3:0] IOPQ    = 4'h6;
  localparam logic [3:0] IJXX    = 4'h7;
  localparam logic [3:0] ICALL   = 4'h8;
  localparam logic [3:0] IRET    = 4'h9;
  localparam logic [3:0] IPUSHQ  = 4'hA;
  localparam logic [3:0] IPOPQ   = 4'hB;

  localparam logic [2:0] SAOK = 3'd1;
  localparam logic [2:0] SHLT = 3'd2;
  localparam logic [2:0] SADR = 3'd3;
  localparam logic [2:0] SINS = 3'd4;

  localparam int SE_F   = 0;
  localparam int SE_D   = 1;
  localparam int SE_E   = 2;
  localparam int SE_M   = 3;
  localparam int SE_W   = 4;
  localparam int SE_PCU = 5;

  typedef enum logic [2:0] {
    ST_IDLE, ST_FETCH, ST_DECODE, ST_EXECUTE,
    ST_MEMORY, ST_WRITEBACK, ST_PCUPD, ST_HALT
  } stage_state_t;

  function automatic logic needs_mem(input logic [3:0] ic);
    return (ic == IRMMOVQ) || (ic == IMRMOVQ) || (ic == ICALL) ||
           (ic == IRET) || (ic == IPUSHQ) || (ic == IPOPQ);
  endfunction

  function automatic logic [5:0] stage_onehot(input stage_state_t s);
    logic [5:0] v;
    v = '0;
    case (s)
      ST_FETCH:     v[SE_F]   = 1'b1;
      ST_DECODE:    v[SE_D]   = 1'b1;
      ST_EXECUTE:   v[SE_E]   = 1'b1;
      ST_MEMORY:    v[SE_M]   = 1'b1;
      ST_WRITEBACK: v[SE_W]   = 1'b1;
      ST_PCUPD:     v[SE_PCU] = 1'b1;
      default:      v         = '0;
    endcase
    return v;
  endfunction

endpackage

// File: rtl/seq_stage_ctrl_if.sv
// Instruction/data memory handshake bundle between the sequencer (master)
// and the fetch/memory side (slave). A req stays high until the cycle its ack is seen.
interface seq_stage_ctrl_if;
  logic       fetch_req;
  logic       fetch_ack;
  logic [3:0] icode;
  logic       instr_valid;
  logic       imem_err;
  logic       dmem_req;
  logic       mem_ack;
  logic       dmem_err;

  modport master (
    output fetch_req, dmem_req,
    input  fetch_ack, icode, instr_valid, imem_err, mem_ack, dmem_err
  );

  modport slave (
    input  fetch_req, dmem_req,
    output fetch_ack, icode, instr_valid, imem_err, mem_ack, dmem_err
  );
endinterface

// File: rtl/seq_stage_ctrl_timer.sv
// Wait-cycle timer shared by the fetch and data-memory waits; fires on the
// TIMEOUT-th unacknowledged cycle, and an ack in that cycle suppresses it.
module mem_wait_timer #(
  parameter int TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clear_i,
  input  logic run_i,
  input  logic ack_i,
  output logic timeout_o
);
  localparam int W = $clog2(TIMEOUT + 1);

  logic [W-1:0] cnt_q;

  assign timeout_o = run_i && !ack_i && (cnt_q == W'(TIMEOUT - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (clear_i) begin
      cnt_q <= '0;
    end else if (run_i && !ack_i && !timeout_o) begin
      cnt_q <= cnt_q + W'(1);
    end
  end
endmodule

// File: rtl/seq_stage_ctrl.sv
// Multi-cycle SEQ Y86-64 sequencer: owns the PC, walks one-hot stage enables,
// runs memory handshakes with timeout and tracks status plus counters.
module seq_stage_ctrl
  import y86_pkg::*;
#(
  parameter logic [63:0] RESET_PC    = 64'h0,
  parameter int          MEM_TIMEOUT = 16,
  parameter int          CNT_W       = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  seq_stage_ctrl_if.master    bus,
  input  logic [63:0]         new_pc,
  output logic [63:0]         pc,
  output logic [5:0]          stage_en,
  output logic [2:0]          stat,
  output logic                halted,
  output logic [CNT_W-1:0]    cycle_cnt,
  output logic [CNT_W-1:0]    instr_cnt,
  output stage_state_t        state_dbg
);
  stage_state_t     state_q, state_d;
  logic [63:0]      pc_q;
  logic [2:0]       stat_q, stat_d;
  logic [3:0]       icode_q, icode_d;
  logic [5:0]       stage_en_q;
  logic             fetch_req_q, dmem_req_q, halted_q;
  logic [CNT_W-1:0] cycle_cnt_q, instr_cnt_q;
  logic             retire, commit_pc, timeout, wait_ack;

  assign wait_ack = (state_q == ST_FETCH) ? bus.fetch_ack : bus.mem_ack;

  mem_wait_timer #(.TIMEOUT(MEM_TIMEOUT)) u_timer (
    .clk       (clk),
    .rst       (rst),
    .clear_i   (!(state_q == ST_FETCH || state_q == ST_MEMORY)),
    .run_i     (fetch_req_q || dmem_req_q),
    .ack_i     (wait_ack),
    .timeout_o (timeout)
  );

  always_comb begin
    state_d   = state_q;
    stat_d    = stat_q;
    icode_d   = icode_q;
    retire    = 1'b0;
    commit_pc = 1'b0;
    case (state_q)
      ST_IDLE:      if (start) state_d = ST_FETCH;
      ST_FETCH: begin
        if (bus.fetch_ack) begin
          icode_d = bus.icode;
          if (bus.imem_err) begin
            stat_d  = SADR;
            state_d = ST_HALT;
          end else if (!bus.instr_valid) begin
            stat_d  = SINS;
            state_d = ST_HALT;
          end else if (bus.icode == IHALT) begin
            stat_d  = SHLT;
            state_d = ST_HALT;
            retire  = 1'b1;
          end else begin
            state_d = ST_DECODE;
          end
        end else if (timeout) begin
          stat_d  = SADR;
          state_d = ST_HALT;
        end
      end
      ST_DECODE:    state_d = ST_EXECUTE;
      ST_EXECUTE:   state_d = ST_MEMORY;
      ST_MEMORY: begin
        if (!needs_mem(icode_q)) begin
          state_d = ST_WRITEBACK;
        end else if (bus.mem_ack) begin
          if (bus.dmem_err) begin
            stat_d  = SADR;
            state_d = ST_HALT;
          end else begin
            state_d = ST_WRITEBACK;
          end
        end else if (timeout) begin
          stat_d  = SADR;
          state_d = ST_HALT;
        end
      end
      ST_WRITEBACK: state_d = ST_PCUPD;
      ST_PCUPD: begin
        commit_pc = 1'b1;
        retire    = 1'b1;
        state_d   = ST_FETCH;
      end
      default:      state_d = ST_HALT;
    endcase
  end

  // Outputs are registered from the next state so they line up with state_q.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      pc_q        <= RESET_PC;
      stat_q      <= SAOK;
      icode_q     <= IHALT;
      stage_en_q  <= '0;
      fetch_req_q <= 1'b0;
      dmem_req_q  <= 1'b0;
      halted_q    <= 1'b0;
      cycle_cnt_q <= '0;
      instr_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      stat_q      <= stat_d;
      icode_q     <= icode_d;
      stage_en_q  <= stage_onehot(state_d);
      fetch_req_q <= (state_d == ST_FETCH);
      dmem_req_q  <= (state_d == ST_MEMORY) && needs_mem(icode_d);
      halted_q    <= (state_d == ST_HALT);
      if (commit_pc) pc_q <= new_pc;
      if (retire && (instr_cnt_q != {CNT_W{1'b1}}))
        instr_cnt_q <= instr_cnt_q + CNT_W'(1);
      if ((state_q != ST_IDLE) && (state_q != ST_HALT) && (cycle_cnt_q != {CNT_W{1'b1}}))
        cycle_cnt_q <= cycle_cnt_q + CNT_W'(1);
    end
  end

  assign pc            = pc_q;
  assign stage_en      = stage_en_q;
  assign stat          = stat_q;
  assign halted        = halted_q;
  assign cycle_cnt     = cycle_cnt_q;
  assign instr_cnt     = instr_cnt_q;
  assign state_dbg     = state_q;
  assign bus.fetch_req = fetch_req_q;
  assign bus.dmem_req  = dmem_req_q;
endmodule

// File: doc/seq_stage_ctrl.md
Name: seq_stage_ctrl

Overview:
- Multi-cycle sequencer for the SEQ Y86-64 core.
- Owns the architectural PC register and one-hot stage enables: fetch, decode, execute, memory, writeback, PC update.
- Handles instruction/data memory request-acknowledge handshakes with a timeout.
- Commits new_pc from the PC-update logic and tracks processor status (AOK/HLT/ADR/INS) plus cycle and retired-instruction counters.

Parameters:
- RESET_PC, 64'h0, PC value loaded on reset.
- MEM_TIMEOUT, 16, maximum cycles to wait for fetch_ack or mem_ack before raising ADR.
- CNT_W, 32, width of the cycle and instruction counters.

Ports:
- clk  in  1  core clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  in IDLE, begins execution at pc.
- icode  in  4  instruction code from fetch; sampled on the fetch_ack cycle.
- instr_valid  in  1  fetch decoded a legal icode/ifun.
- imem_err  in  1  instruction memory address error; qualified by fetch_ack.
- fetch_ack  in  1  instruction bytes valid this cycle.
- dmem_err  in  1  data memory address error; qualified by mem_ack.
- mem_ack  in  1  data access complete this cycle.
- new_pc  in  64  next PC from the PC-update datapath.
- pc  out  64  current architectural PC.
- stage_en  out  6  one-hot enable; bit0 F, 1 D, 2 E, 3 M, 4 W, 5 PCU.
- fetch_req  out  1  instruction fetch request.
- dmem_req  out  1  data memory request.
- stat  out  3  1=AOK, 2=HLT, 3=ADR, 4=INS.
- halted  out  1  FSM in HALT.
- cycle_cnt  out  CNT_W  active cycles, saturating.
- instr_cnt  out  CNT_W  retired instructions, saturating.

Behaviour:
- Reset: state IDLE, pc=RESET_PC, stat=1, stage_en=0, fetch_req=0, dmem_req=0, halted=0, counters=0, timer=0.
- Reset mid-instruction aborts immediately; no partial PC commit.
- States: IDLE, FETCH, DECODE, EXECUTE, MEMORY, WRITEBACK, PCUPD, HALT. Outputs are registered from state.
- IDLE:
  - start=1 moves to FETCH.
  - start is ignored in every other state.
- FETCH: stage_en[0]=1, fetch_req=1 held until fetch_ack. On the ack cycle, first match wins:
  - imem_err: stat=3, go HALT.
  - !instr_valid: stat=4, go HALT.
  - icode==0 (halt): stat=2, go HALT; instr_cnt+1; pc unchanged.
  - Otherwise: go DECODE.
- DECODE, EXECUTE, WRITEBACK: one cycle each, corresponding stage_en bit set.
- MEMORY:
  - needs_mem = icode in {4,5,8,9,A,B}, using icode latched at fetch_ack.
  - If needs_mem: dmem_req=1 held until mem_ack. On ack, dmem_err sets stat=3 and goes HALT; otherwise go WRITEBACK.
  - Else: one cycle, dmem_req=0.
- Timeout:
  - Wait counter clears on entry to FETCH or MEMORY and increments each cycle with no ack.
  - Reaching MEM_TIMEOUT sets stat=3 and goes HALT.
  - An ack in the same cycle as the timeout wins; the timeout is ignored.
- PCUPD: stage_en[5]=1; pc<=new_pc; instr_cnt+1; go FETCH.
- Minimum latency with ack in the request cycle: 6 cycles per instruction.
- HALT: halted=1, all enables and requests 0, stat frozen, pc frozen; exit only via rst.
- cycle_cnt increments in every state except IDLE and HALT.
- Both counters saturate at all-ones and never wrap.
- Exactly one stage_en bit is high in active states; all are 0 in IDLE and HALT.

Decomposition:
- Package y86_pkg: icode constants (IHALT=0 … IPOPQ=B), stat codes SAOK/SHLT/SADR/SINS, stage state enum, stage_en bit indices.
- Sub-module mem_wait_timer: clear/run/ack inputs, timeout output; shared by the FETCH and MEMORY waits.

Test Plan:
- Reset, start, icode=6 (OPq), acks immediate, new_pc=0x2 -> stage_en walks 1,2,4,8,16,32; pc=0x2 after 6 cycles; instr_cnt=1; stat=1.
- icode=5 (mrmovq), mem_ack delayed 3 cycles -> dmem_req high exactly 4 cycles; total 9 cycles; pc=new_pc.
- icode=0 at pc=0x40 -> stat=2, halted=1, pc stays 0x40, instr_cnt=1; later start pulses ignored.
- fetch_ack never arrives, MEM_TIMEOUT=16 -> HALT with stat=3 after 16 wait cycles; mem_ack on the 16th cycle instead -> proceeds normally.
- fetch_ack with instr_valid=0 -> stat=4. mem_ack with dmem_err=1 on icode=A -> stat=3; instr_cnt unchanged.
- rst asserted asynchronously during MEMORY -> outputs at reset values without a clock edge; pc=RESET_PC.
